// File: rtl/led_array_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_ctrl_pkg
//  Description : Shared constants and helpers for the LED array controller:
//                channel mode codes, frame width derivation and the
//                broadcast address.
//  Revision    : 1.0 - initial release
// ============================================================================
package led_ctrl_pkg;

    // Channel mode codes carried in the frame mode field
    localparam logic [2:0] MODE_OFF       = 3'd0;
    localparam logic [2:0] MODE_ON        = 3'd1;
    localparam logic [2:0] MODE_PAT1      = 3'd2;
    localparam logic [2:0] MODE_PAT2      = 3'd3;
    localparam logic [2:0] MODE_BLINK_A   = 3'd4;
    localparam logic [2:0] MODE_BLINK_B   = 3'd5;
    localparam logic [2:0] MODE_PAT1_N    = 3'd6;
    localparam logic [2:0] MODE_BLINK_A_N = 3'd7;

    // A frame is the mode field followed by the address field
    function automatic int frame_w(input int mode_w, input int addr_w);
        return mode_w + addr_w;
    endfunction

    // The all-ones address selects every channel
    function automatic int bcast_addr(input int addr_w);
        return (1 << addr_w) - 1;
    endfunction

endpackage : led_ctrl_pkg
`default_nettype wire

// File: rtl/led_array_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : led_array_ctrl_if
//  Description : Serial frame, pattern and LED output bundle of the LED
//                array controller. SDO exists only when LED_SDO_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface led_array_ctrl_if #(
    parameter int N_LED = 20
);
    logic             SCK;
    logic             DATA;
    logic             LATCH;
    logic             PATTERN1;
    logic             PATTERN2;
    logic [N_LED-1:0] LED;
    logic             FRAME_ERR;
`ifdef LED_SDO_EN
    logic             SDO;

    modport master (output SCK, DATA, LATCH, PATTERN1, PATTERN2,
                    input  LED, FRAME_ERR, SDO);
    modport slave  (input  SCK, DATA, LATCH, PATTERN1, PATTERN2,
                    output LED, FRAME_ERR, SDO);
`else
    modport master (output SCK, DATA, LATCH, PATTERN1, PATTERN2,
                    input  LED, FRAME_ERR);
    modport slave  (input  SCK, DATA, LATCH, PATTERN1, PATTERN2,
                    output LED, FRAME_ERR);
`endif
endinterface : led_array_ctrl_if
`default_nettype wire

// File: rtl/led_array_ctrl_chan_mux.sv
`default_nettype none
// ============================================================================
//  Module      : led_chan_mux
//  Description : Combinational mode-to-level select for one LED channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_chan_mux
    import led_ctrl_pkg::*;
#(
    parameter int MODE_W = 3
) (
    input  wire logic [MODE_W-1:0] i_mode,
    input  wire logic              i_pat1,
    input  wire logic              i_pat2,
    input  wire logic              i_blink_a,
    input  wire logic              i_blink_b,
    output logic                   o_level
);

    // Decode the channel mode into the level it should drive
    always_comb begin
        o_level = 1'b0;
        case (i_mode)
            MODE_W'(MODE_OFF):       o_level = 1'b0;
            MODE_W'(MODE_ON):        o_level = 1'b1;
            MODE_W'(MODE_PAT1):      o_level = i_pat1;
            MODE_W'(MODE_PAT2):      o_level = i_pat2;
            MODE_W'(MODE_BLINK_A):   o_level = i_blink_a;
            MODE_W'(MODE_BLINK_B):   o_level = i_blink_b;
            MODE_W'(MODE_PAT1_N):    o_level = ~i_pat1;
            MODE_W'(MODE_BLINK_A_N): o_level = ~i_blink_a;
            default:                 o_level = 1'b0;
        endcase
    end

endmodule : led_chan_mux
`default_nettype wire

// File: rtl/led_array_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : led_array_ctrl
//  Description : Serial-addressed LED array controller. Frames arrive on
//                SCK/DATA (all inputs synchronised to CLK, edges detected),
//                are committed on a LATCH rising edge, and set a per-channel
//                mode that selects off/on/pattern/blink for a registered LED.
//                Optional macro LED_SDO_EN adds the SDO daisy-chain output
//                and relaxes the bit-count check to ">= frame width".
//  Revision    : 1.0 - initial release
// ============================================================================
module led_array_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int N_LED       = 20,
    parameter int ADDR_W      = 5,
    parameter int MODE_W      = 3,
    parameter int SYNC_STAGES = 2,
    parameter int BLINK_DIV_W = 16
) (
    input  wire logic          CLK,
    input  wire logic          RESET,
    led_array_ctrl_if.slave    bus
);

    localparam int FRAME_W = frame_w(MODE_W, ADDR_W);
    localparam int CNT_W   = $clog2(FRAME_W + 2);
`ifdef LED_SDO_EN
    localparam int CNT_MAX = FRAME_W;
`else
    localparam int CNT_MAX = FRAME_W + 1;
`endif

    // Bit positions of the asynchronous inputs inside the synchroniser bus
    localparam int IX_SCK  = 0;
    localparam int IX_DATA = 1;
    localparam int IX_LAT  = 2;
    localparam int IX_P1   = 3;
    localparam int IX_P2   = 4;

    logic [4:0]             w_async;
    logic [4:0]             r_sync [SYNC_STAGES];
    logic [4:0]             w_s;
    logic                   r_sck_d;
    logic                   r_lat_d;
    logic                   w_sck_rise;
    logic                   w_lat_rise;
    logic [FRAME_W-1:0]     r_shift;
    logic [CNT_W-1:0]       r_cnt;
    logic [MODE_W-1:0]      w_mode_f;
    logic [ADDR_W-1:0]      w_addr_f;
    logic                   w_cnt_ok;
    logic                   w_bcast;
    logic                   w_in_range;
    logic                   w_accept;
    logic [MODE_W-1:0]      r_mode [N_LED];
    logic                   r_frame_err;
    logic [BLINK_DIV_W-1:0] r_presc;
    logic [N_LED-1:0]       w_level;
    logic [N_LED-1:0]       r_led;

    assign w_async = {bus.PATTERN2, bus.PATTERN1, bus.LATCH, bus.DATA, bus.SCK};

    // Multi-stage synchroniser for every asynchronous input
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= w_async;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // Delayed copies of synchronised SCK/LATCH for rising-edge detection
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_sck_d <= 1'b0;
            r_lat_d <= 1'b0;
        end else begin
            r_sck_d <= w_s[IX_SCK];
            r_lat_d <= w_s[IX_LAT];
        end
    end

    assign w_sck_rise = w_s[IX_SCK] & ~r_sck_d;
    assign w_lat_rise = w_s[IX_LAT] & ~r_lat_d;

    // Frame shift register and saturating bit counter; cleared on commit
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_lat_rise) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_sck_rise && !w_s[IX_LAT]) begin
            r_shift <= {r_shift[FRAME_W-2:0], w_s[IX_DATA]};
            if (r_cnt != CNT_W'(CNT_MAX)) r_cnt <= r_cnt + 1'b1;
        end
    end

`ifdef LED_SDO_EN
    logic r_sdo;

    // Daisy-chain output tracks the shift-register MSB after each shift
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_sdo <= 1'b0;
        end else if (w_sck_rise && !w_s[IX_LAT] && !w_lat_rise) begin
            r_sdo <= r_shift[FRAME_W-2];
        end
    end

    assign bus.SDO  = r_sdo;
    assign w_cnt_ok = (r_cnt >= CNT_W'(FRAME_W));
`else
    assign w_cnt_ok = (r_cnt == CNT_W'(FRAME_W));
`endif

    assign w_mode_f   = r_shift[FRAME_W-1 -: MODE_W];
    assign w_addr_f   = r_shift[ADDR_W-1:0];
    assign w_bcast    = (int'(w_addr_f) == bcast_addr(ADDR_W));
    assign w_in_range = (int'(w_addr_f) < N_LED);
    assign w_accept   = w_cnt_ok && (w_bcast || w_in_range);

    // Commit a frame: update the addressed channel(s) and the error flag
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < N_LED; i++) r_mode[i] <= '0;
            r_frame_err <= 1'b0;
        end else if (w_lat_rise) begin
            for (int i = 0; i < N_LED; i++) begin
                if (w_accept && (w_bcast || int'(w_addr_f) == i)) r_mode[i] <= w_mode_f;
            end
            r_frame_err <= ~w_accept;
        end
    end

    // Free-running blink prescaler, untouched by frame traffic
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) r_presc <= '0;
        else        r_presc <= r_presc + 1'b1;
    end

    generate
        for (genvar g = 0; g < N_LED; g++) begin : g_chan
            led_chan_mux #(.MODE_W(MODE_W)) u_mux (
                .i_mode    (r_mode[g]),
                .i_pat1    (w_s[IX_P1]),
                .i_pat2    (w_s[IX_P2]),
                .i_blink_a (r_presc[BLINK_DIV_W-1]),
                .i_blink_b (r_presc[BLINK_DIV_W-2]),
                .o_level   (w_level[g])
            );
        end
    endgenerate

    // Register the decoded channel levels onto the LED outputs
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) r_led <= '0;
        else        r_led <= w_level;
    end

    assign bus.LED       = r_led;
    assign bus.FRAME_ERR = r_frame_err;

endmodule : led_array_ctrl
`default_nettype wire

// File: tb/tb_led_array_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_array_ctrl
//  Description : Scoreboard bench for led_array_ctrl (20 channels, 4-bit
//                blink prescaler). Stimulus queues expected LED/FRAME_ERR
//                values tagged with the cycle they are due; a monitor
//                compares them on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_array_ctrl;

    localparam int N_LED = 20;
    localparam logic [N_LED-1:0] ALL = 20'hFFFFF;
    localparam logic [N_LED-1:0] HI  = 20'hFFFF8;   // excludes blinking ch0..2

    logic CLK;
    logic RESET;
    int   cyc;
    int   base;
    int   n_cmp;
    int   n_bad;

    typedef struct {
        int               due;
        logic [N_LED-1:0] mask;
        logic [N_LED-1:0] led;
        logic             err;
        logic [8*8-1:0]   tag;
    } exp_t;

    exp_t q[$];
    exp_t e;

    led_array_ctrl_if #(.N_LED(N_LED)) bus();

    led_array_ctrl #(
        .N_LED       (N_LED),
        .ADDR_W      (5),
        .MODE_W      (3),
        .SYNC_STAGES (2),
        .BLINK_DIV_W (4)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: compare every expectation that falls due on this cycle
    always @(negedge CLK) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            n_cmp = n_cmp + 1;
            if (e.due != cyc) begin
                n_bad = n_bad + 1;
                $display("FAIL %0s: check due at cycle %0d missed (now %0d)", e.tag, e.due, cyc);
            end else if (((bus.LED & e.mask) != (e.led & e.mask)) || (bus.FRAME_ERR !== e.err)) begin
                n_bad = n_bad + 1;
                $display("FAIL %0s @%0d: LED=%05h ERR=%0b, want LED=%05h ERR=%0b (mask %05h)",
                         e.tag, cyc, bus.LED & e.mask, bus.FRAME_ERR, e.led & e.mask, e.err, e.mask);
            end
        end
    end

    task automatic push(input int due, input logic [N_LED-1:0] mask,
                        input logic [N_LED-1:0] led, input logic err,
                        input logic [8*8-1:0] tag);
        q.push_back('{due: due, mask: mask, led: led, err: err, tag: tag});
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Shift n bits MSB first, holding each level long enough to synchronise
    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus.DATA = bits[i];
            tick(3);
            bus.SCK = 1'b1;
            tick(3);
            bus.SCK = 1'b0;
            tick(3);
        end
    endtask

    // Pulse LATCH; LATCH is sampled at c+1, flag moves at c+3, LED at c+4
    task automatic commit(input logic [N_LED-1:0] led_old, input logic [N_LED-1:0] led_new,
                          input logic err_old, input logic err_new,
                          input logic [N_LED-1:0] mask, input logic [8*8-1:0] tag);
        int c;
        bus.LATCH = 1'b1;
        c = cyc;
        push(c + 2, mask, led_old, err_old, tag);
        push(c + 3, mask, led_old, err_new, tag);
        push(c + 4, mask, led_new, err_new, tag);
        tick(4);
        bus.LATCH = 1'b0;
        tick(4);
    endtask

    // Change a pattern input; sampled at c+1, LED follows at c+3
    task automatic set_pat(input int which, input logic v,
                           input logic [N_LED-1:0] led_old, input logic [N_LED-1:0] led_new,
                           input logic err, input logic [N_LED-1:0] mask,
                           input logic [8*8-1:0] tag);
        int c;
        if (which == 1) bus.PATTERN1 = v;
        else            bus.PATTERN2 = v;
        c = cyc;
        push(c + 2, mask, led_old, err, tag);
        push(c + 3, mask, led_new, err, tag);
        tick(4);
    endtask

    initial begin
        logic [3:0]       p;
        logic [N_LED-1:0] w;
        int               d;
        cyc = 0; n_cmp = 0; n_bad = 0; base = 0;
        RESET = 1'b0;
        bus.SCK = 1'b0; bus.DATA = 1'b0; bus.LATCH = 1'b0;
        bus.PATTERN1 = 1'b0; bus.PATTERN2 = 1'b0;
        tick(3);
        RESET = 1'b1;
        base = cyc;
        push(cyc + 1, ALL, '0, 1'b0, "reset");
        tick(2);

        // Single-channel frame: mode ON to channel 3
        send_bits(16'b001_00011, 8);
        commit('0, 20'h00008, 1'b0, 1'b0, ALL, "ch3_on");

        // Broadcast PAT1 then follow PATTERN1 on every channel
        send_bits(16'b010_11111, 8);
        commit(20'h00008, '0, 1'b0, 1'b0, ALL, "bcast");
        set_pat(1, 1'b1, '0, ALL, 1'b0, ALL, "pat1_up");
        set_pat(1, 1'b0, ALL, '0, 1'b0, ALL, "pat1_dn");
        set_pat(1, 1'b1, '0, ALL, 1'b0, ALL, "pat1_up2");

        // Short frame (7 bits) rejected, valid frame clears the flag
        send_bits(16'b0010000, 7);
        commit(ALL, ALL, 1'b0, 1'b1, ALL, "short");
        send_bits(16'b000_00000, 8);
        commit(ALL, 20'hFFFFE, 1'b1, 1'b0, ALL, "ch0_off");

        // Address 25 (beyond N_LED, not broadcast) rejected
        send_bits(16'b001_11001, 8);
        commit(20'hFFFFE, 20'hFFFFE, 1'b0, 1'b1, ALL, "addr25");
        send_bits(16'b001_00000, 8);
        commit(20'hFFFFE, ALL, 1'b1, 1'b0, ALL, "ch0_on");

        // Nine bits: counter saturates, frame rejected
        send_bits(16'b1_000_00000, 9);
        commit(ALL, ALL, 1'b0, 1'b1, ALL, "long9");

        // PAT2 on ch4 (PATTERN2 low), ~PAT1 on ch5 (PATTERN1 high)
        send_bits(16'b011_00100, 8);
        commit(ALL, 20'hFFFEF, 1'b1, 1'b0, ALL, "ch4_pat2");
        send_bits(16'b110_00101, 8);
        commit(20'hFFFEF, 20'hFFFCF, 1'b0, 1'b0, ALL, "ch5_p1n");

        // Blink A on ch0, ~blink A on ch1, blink B on ch2
        send_bits(16'b100_00000, 8);
        commit(20'hFFFCF, 20'hFFFCF, 1'b0, 1'b0, HI, "ch0_bA");
        send_bits(16'b111_00001, 8);
        commit(20'hFFFCF, 20'hFFFCF, 1'b0, 1'b0, HI, "ch1_bAn");
        send_bits(16'b101_00010, 8);
        commit(20'hFFFCF, 20'hFFFCF, 1'b0, 1'b0, HI, "ch2_bB");

        // LED after edge d reflects prescaler value (d-1-base)
        for (int i = 0; i < 40; i++) begin
            d = cyc + 1;
            p = 4'(d - 1 - base);
            w = 20'hFFFC8 | {17'b0, p[2], ~p[3], p[3]};
            push(d, ALL, w, 1'b0, "blink");
            tick(1);
        end

        set_pat(2, 1'b1, 20'hFFFC8, 20'hFFFD8, 1'b0, HI, "pat2_up");
        set_pat(1, 1'b0, 20'hFFFD8, 20'h00030, 1'b0, HI, "pat1_lo");

        // Reset in the middle of a frame, then a complete frame to ch5
        send_bits(16'b0010, 4);
        RESET = 1'b0;
        push(cyc + 1, ALL, '0, 1'b0, "midrst");
        tick(3);
        RESET = 1'b1;
        base = cyc;
        tick(2);
        send_bits(16'b001_00101, 8);
        commit('0, 20'h00020, 1'b0, 1'b0, ALL, "ch5_on");

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 50 && q.size() > 0; i++) tick(1);
        while (q.size() > 0) begin
            e = q.pop_front();
            n_cmp = n_cmp + 1;
            n_bad = n_bad + 1;
            $display("FAIL %0s: expectation due at %0d never checked", e.tag, e.due);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_led_array_ctrl
`default_nettype wire

// File: doc/led_array_ctrl.md
Name: led_array_ctrl

Overview:
- Parametrised successor to the serial-addressed LED controller. Serial frames are received on SCK/DATA and committed on LATCH.
- Each frame sets a 3-bit mode on one LED channel, or on all channels.
- Fully synchronous to CLK. SCK, DATA, LATCH and the pattern inputs are synchronised and edge-detected internally, not used as clocks.
- Adds internal blink generators, broadcast addressing, frame validation and a registered LED output.

Parameters:
- N_LED, 20, number of LED channels (1..2**ADDR_W-1).
- ADDR_W, 5, address field width; the all-ones address is broadcast.
- MODE_W, 3, mode field width.
- SYNC_STAGES, 2, synchroniser flops on each asynchronous input (>=2).
- BLINK_DIV_W, 16, width of the internal blink prescaler.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-low reset.
- SCK  in  1  serial bit clock (async); DATA is sampled on its rising edge.
- DATA  in  1  serial data, MSB first.
- LATCH  in  1  frame commit (async); acts on its rising edge.
- PATTERN1  in  1  external pattern source 1 (async).
- PATTERN2  in  1  external pattern source 2 (async).
- LED  out  N_LED  registered LED drive; bit i belongs to channel i.
- FRAME_ERR  out  1  sticky error flag; cleared by the next valid frame.
- SDO  out  1  daisy-chain output; only present with LED_SDO_EN.

Behaviour:
- Reset (RESET=0, async):
  - every channel mode = 0 (off); LED = 0; FRAME_ERR = 0.
  - shift register, bit counter and prescaler = 0; synchronisers = 0.
- Frame format: FRAME_W = MODE_W+ADDR_W (8 with defaults), MSB first: mode[MODE_W-1:0], then addr[ADDR_W-1:0].
- Shifting:
  - On a synchronised SCK rising edge with synchronised LATCH low: shift register left, LSB <= synchronised DATA.
  - The bit counter increments and saturates at FRAME_W+1.
  - SCK edges are ignored while synchronised LATCH is high.
- Commit, on a synchronised LATCH rising edge:
  - Bit counter == FRAME_W and addr < N_LED: mode[addr] <= mode field; FRAME_ERR <= 0.
  - Bit counter == FRAME_W and addr == all-ones: every channel mode <= mode field; FRAME_ERR <= 0.
  - Otherwise (wrong bit count, or N_LED <= addr < all-ones): no channel changes; FRAME_ERR <= 1.
  - In all cases the bit counter is cleared to 0 and the shift register is cleared to 0.
- Commit latency: a LATCH high sampled at CLK edge k updates mode at edge k+SYNC_STAGES and LED at edge k+SYNC_STAGES+1.
- Mode decode, per channel, LED registered:
  - 0: off (0).
  - 1: on (1).
  - 2: synchronised PATTERN1.
  - 3: synchronised PATTERN2.
  - 4: blink A = prescaler[BLINK_DIV_W-1].
  - 5: blink B = prescaler[BLINK_DIV_W-2] (twice the rate of A).
  - 6: ~PATTERN1.
  - 7: ~blink A (antiphase with mode 4).
- Prescaler: free-running, +1 every CLK, wraps from all-ones to 0. It is never reset by frames.
- Reset mid-frame: partial frame lost. After release, the first LATCH with fewer than FRAME_W bits sets FRAME_ERR.
- More than FRAME_W bits before LATCH: the counter saturates, so the frame is rejected and FRAME_ERR is set.

Optional Feature:
- Macro: LED_SDO_EN.
- Defined:
  - SDO = registered shift-register MSB, updated on the same CLK edge as each shift.
  - N cascaded devices take N*FRAME_W bits followed by one shared LATCH.
  - The bit-count check then accepts counts >= FRAME_W: the last FRAME_W bits win, and the counter saturates at FRAME_W.
- Undefined: no SDO port; the exact-count rule applies.

Decomposition:
- Package led_ctrl_pkg holds:
  - mode constants: MODE_OFF, MODE_ON, MODE_PAT1, MODE_PAT2, MODE_BLINK_A, MODE_BLINK_B, MODE_PAT1_N, MODE_BLINK_A_N;
  - the FRAME_W derivation;
  - the broadcast-address function.
- One sub-module, led_chan_mux: combinational mode-to-level select for one channel, instantiated N_LED times by generate.
- Synchronisers and the edge detect stay inline.

Test Plan:
- After reset, shift 8'b001_00011 and pulse LATCH -> LED[3]=1 SYNC_STAGES+1 CLK edges after LATCH is sampled high; other LEDs 0; FRAME_ERR=0.
- Broadcast 8'b010_11111, then toggle PATTERN1 -> all 20 LEDs follow PATTERN1 with a 3-cycle delay.
- Shift only 7 bits of 8'b001_00000, then LATCH -> LED[0] unchanged, FRAME_ERR=1; a valid frame afterwards clears FRAME_ERR.
- Frame 8'b001_11001 (addr 25, N_LED=20) -> no LED change, FRAME_ERR=1.
- BLINK_DIV_W=4, frames mode 4 to ch0 and mode 7 to ch1 -> LED[0] toggles every 8 CLK and LED[1]=~LED[0] throughout.
- Assert RESET after 4 of 8 bits, release, then send a complete frame 8'b001_00101 -> LED[5]=1, FRAME_ERR=0, all other LEDs 0.
